// File: rtl/acl2_sampler_if.sv
// Request/response bundle between acl2_sampler and the ACL2 SPI controller.
interface acl2_sampler_if;
    logic        action_read;
    logic [7:0]  addr;
    logic [7:0]  din;
    logic        finished;
    logic [11:0] dout;

    modport master (output action_read, addr, din, input finished, dout);
    modport slave  (input action_read, addr, din, output finished, dout);
endinterface

// File: rtl/acl2_sampler.sv
// ADXL362 init + X/Y/Z read sequencer feeding the ACL2 SPI controller.
// Optional device-ID check enabled by defining ACL2_DEVID_CHECK_EN.
module acl2_sampler #(
    parameter int unsigned RST_WAIT_CYCLES = 5000,
    parameter logic [7:0]  FILTER_CTL      = 8'h13,
    parameter logic [7:0]  POWER_CTL       = 8'h02
) (
    input  logic                  clk,
    input  logic                  rst,
    acl2_sampler_if.master        bus,
    output logic [11:0]           x,
    output logic [11:0]           y,
    output logic [11:0]           z,
    output logic                  sample_valid,
    output logic                  init_done,
    output logic                  err
);

    localparam int unsigned CNT_W = $clog2(RST_WAIT_CYCLES + 1);
    localparam int unsigned REQ_W = 17;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(RST_WAIT_CYCLES);
    localparam logic [REQ_W-1:0] REQ_RESET = {1'b0, 8'h1F, 8'h52};

    typedef enum logic [2:0] {
        S_SRST, S_WAIT, S_ID, S_FILT, S_PWR, S_RDX, S_RDY, S_RDZ
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [11:0]      sx;
    logic [11:0]      sy;
    logic [REQ_W-1:0] req;

    // Request word {action_read, addr, din} issued while sitting in a state.
    function automatic logic [REQ_W-1:0] req_of(input state_t s);
        case (s)
            S_SRST:       req_of = REQ_RESET;
            S_WAIT, S_ID: req_of = {1'b1, 8'h00, 8'h00};
            S_FILT:       req_of = {1'b0, 8'h2C, FILTER_CTL};
            S_PWR:        req_of = {1'b0, 8'h2D, POWER_CTL};
            S_RDX:        req_of = {1'b1, 8'h0E, 8'h00};
            S_RDY:        req_of = {1'b1, 8'h10, 8'h00};
            S_RDZ:        req_of = {1'b1, 8'h12, 8'h00};
            default:      req_of = REQ_RESET;
        endcase
    endfunction

    assign {bus.action_read, bus.addr, bus.din} = req;

`ifndef ACL2_DEVID_CHECK_EN
    assign err = 1'b0;
`endif

    // Sequencer: state and request move only on a finished edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_SRST;
            req          <= REQ_RESET;
            wait_cnt     <= '0;
            sx           <= '0;
            sy           <= '0;
            x            <= '0;
            y            <= '0;
            z            <= '0;
            sample_valid <= 1'b0;
            init_done    <= 1'b0;
`ifdef ACL2_DEVID_CHECK_EN
            err          <= 1'b0;
`endif
        end else begin
            sample_valid <= 1'b0;
            if (state == S_WAIT && wait_cnt != CNT_MAX)
                wait_cnt <= wait_cnt + CNT_W'(1);

            if (bus.finished) begin
                case (state)
                    S_SRST: begin
                        state    <= S_WAIT;
                        req      <= req_of(S_WAIT);
                        wait_cnt <= '0;
                    end
                    S_WAIT: begin
                        if (wait_cnt == CNT_MAX) begin
`ifdef ACL2_DEVID_CHECK_EN
                            state <= S_ID;
                            req   <= req_of(S_ID);
`else
                            state <= S_FILT;
                            req   <= req_of(S_FILT);
`endif
                        end
                    end
`ifdef ACL2_DEVID_CHECK_EN
                    S_ID: begin
                        if (bus.dout[7:0] == 8'hAD) begin
                            err   <= 1'b0;
                            state <= S_FILT;
                            req   <= req_of(S_FILT);
                        end else begin
                            err   <= 1'b1;
                            state <= S_SRST;
                            req   <= REQ_RESET;
                        end
                    end
`endif
                    S_FILT: begin
                        state <= S_PWR;
                        req   <= req_of(S_PWR);
                    end
                    S_PWR: begin
                        state     <= S_RDX;
                        req       <= req_of(S_RDX);
                        init_done <= 1'b1;
                    end
                    S_RDX: begin
                        sx    <= bus.dout;
                        state <= S_RDY;
                        req   <= req_of(S_RDY);
                    end
                    S_RDY: begin
                        sy    <= bus.dout;
                        state <= S_RDZ;
                        req   <= req_of(S_RDZ);
                    end
                    S_RDZ: begin
                        // Publish the whole frame at once so x/y/z never mix sets.
                        x            <= sx;
                        y            <= sy;
                        z            <= bus.dout;
                        sample_valid <= 1'b1;
                        state        <= S_RDX;
                        req          <= req_of(S_RDX);
                    end
                    default: begin
                        state <= S_SRST;
                        req   <= REQ_RESET;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acl2_sampler.sv
// Bench for acl2_sampler: behavioural controller + ADXL362 register model, scoreboarded.
module tb_acl2_sampler;

    localparam int W      = 40;
    localparam int L      = 6;
    localparam int BUDGET = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acl2_sampler_if bus ();
    logic [11:0] x, y, z;
    logic        sample_valid, init_done, err;

    acl2_sampler #(.RST_WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .x(x), .y(y), .z(z),
        .sample_valid(sample_valid), .init_done(init_done), .err(err)
    );

    int checks = 0;
    int errors = 0;
    int hold_bad = 0;

    logic [16:0] exp_txn[$];
    logic [35:0] exp_smp[$];

    logic [7:0]  mdev;
    logic [11:0] mx, my, mz;
    logic [16:0] cur, fin_req;
    logic [35:0] prev_xyz;
    int          ccnt;
    bit          start, chg;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] resp(input logic [16:0] r);
        if (!r[16]) return 12'h000;
        case (r[15:8])
            8'h00:   return {4'h0, mdev};
            8'h0E:   return mx;
            8'h10:   return my;
            8'h12:   return mz;
            default: return 12'hFFF;
        endcase
    endfunction

    // Controller model: fixed-length back-to-back transactions; finished held high in reset.
    always @(negedge clk) begin
        if (rst) begin
            bus.finished = 1'b1;
            bus.dout     = 12'hABC;
            ccnt  = 0;
            start = 1'b1;
            chg   = 1'b0;
        end else begin
            if (start) begin
                cur   = {bus.action_read, bus.addr, bus.din};
                start = 1'b0;
                chg   = 1'b0;
            end else if ({bus.action_read, bus.addr, bus.din} !== cur) begin
                chg = 1'b1;
            end
            if (ccnt == L - 1) begin
                bus.finished = 1'b1;
                bus.dout     = resp(cur);
                fin_req      = cur;
                ccnt  = 0;
                start = 1'b1;
                check("req_stable", 64'(chg), 64'(0));
                if (exp_txn.size() > 0) check("txn_order", 64'(cur), 64'(exp_txn.pop_front()));
            end else begin
                bus.finished = 1'b0;
                ccnt++;
            end
        end
    end

    // x/y/z may only move together with sample_valid (or reset).
    always @(negedge clk) begin
        if (!rst && !sample_valid && {x, y, z} !== prev_xyz) hold_bad++;
        prev_xyz = {x, y, z};
    end

    task automatic push_srst_wait();
        int n = 0;
        exp_txn.push_back({1'b0, 8'h1F, 8'h52});
        while (n * L - 1 < W) n++;
        for (int i = 0; i < n; i++) exp_txn.push_back({1'b1, 8'h00, 8'h00});
    endtask

    task automatic push_init();
        push_srst_wait();
`ifdef ACL2_DEVID_CHECK_EN
        exp_txn.push_back({1'b1, 8'h00, 8'h00});
`endif
        exp_txn.push_back({1'b0, 8'h2C, 8'h13});
        exp_txn.push_back({1'b0, 8'h2D, 8'h02});
    endtask

    task automatic push_frames(input int k);
        for (int i = 0; i < k; i++) begin
            exp_txn.push_back({1'b1, 8'h0E, 8'h00});
            exp_txn.push_back({1'b1, 8'h10, 8'h00});
            exp_txn.push_back({1'b1, 8'h12, 8'h00});
        end
    endtask

    task automatic wait_fin(input logic [7:0] a);
        int  n = 0;
        bit  found = 1'b0;
        while (!found && n < BUDGET) begin
            @(negedge clk); #1;
            n++;
            if (bus.finished && !rst && fin_req[15:8] == a) found = 1'b1;
        end
        check($sformatf("fin_timeout_%h", a), 64'(found), 64'(1));
    endtask

    task automatic wait_sample();
        int          n = 0;
        bit          found = 1'b0;
        logic [35:0] e;
        while (!found && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
            if (sample_valid) found = 1'b1;
        end
        check("sample_timeout", 64'(found), 64'(1));
        if (found && exp_smp.size() > 0) begin
            e = exp_smp.pop_front();
            check("sample_x", 64'(x), 64'(e[35:24]));
            check("sample_y", 64'(y), 64'(e[23:12]));
            check("sample_z", 64'(z), 64'(e[11:0]));
        end
        @(posedge clk); #1;
        check("valid_one_cycle", 64'(sample_valid), 64'(0));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"},  64'({bus.action_read, bus.addr, bus.din}), 64'({1'b0, 8'h1F, 8'h52}));
        check({tag, "_xyz"},  64'({x, y, z}), 64'(0));
        check({tag, "_valid"}, 64'(sample_valid), 64'(0));
        check({tag, "_init"}, 64'(init_done), 64'(0));
        check({tag, "_err"},  64'(err), 64'(0));
    endtask

    initial begin
        mdev = 8'hAD;
        mx = 12'h0FF; my = 12'hF01; mz = 12'h800;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");

        // Init order and first frame
        push_init();
        push_frames(3);
        exp_smp.push_back({12'h0FF, 12'hF01, 12'h800});
        rst = 1'b0;
        wait_fin(8'h2D);
        check("init_before_pwr", 64'(init_done), 64'(0));
        @(posedge clk); #1;
        check("init_after_pwr", 64'(init_done), 64'(1));
        wait_sample();

        // Model changes after the X read of the next frame
        wait_fin(8'h0E);
        mx = 12'h123; my = 12'h456; mz = 12'h789;
        exp_smp.push_back({12'h0FF, 12'h456, 12'h789});
        exp_smp.push_back({12'h123, 12'h456, 12'h789});
        wait_fin(8'h10);
        check("held_mid_frame", 64'({x, y, z}), 64'({12'h0FF, 12'hF01, 12'h800}));
        wait_sample();
        wait_sample();
        check("txn_drained_1", 64'(exp_txn.size()), 64'(0));

        // Reset in the middle of the Y read
        wait_fin(8'h0E);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check_reset_state("midrst");
        exp_txn.delete();
        push_init();
        push_frames(1);
        exp_smp.push_back({12'h123, 12'h456, 12'h789});
        rst = 1'b0;
        wait_fin(8'h1F);
        check("restart_w1f", 64'(fin_req), 64'({1'b0, 8'h1F, 8'h52}));
        wait_sample();
        check("txn_drained_2", 64'(exp_txn.size()), 64'(0));

`ifdef ACL2_DEVID_CHECK_EN
        // Wrong device ID forces a full retry; correct ID then clears err
        rst = 1'b1;
        mdev = 8'h00;
        repeat (2) begin @(posedge clk); #1; end
        exp_txn.delete();
        push_srst_wait();
        exp_txn.push_back({1'b1, 8'h00, 8'h00});
        push_init();
        rst = 1'b0;
        wait_fin(8'h1F);
        wait_fin(8'h1F);
        check("devid_err_set", 64'(err), 64'(1));
        check("devid_no_init", 64'(init_done), 64'(0));
        mdev = 8'hAD;
        wait_fin(8'h2D);
        @(posedge clk); #1;
        check("devid_err_clear", 64'(err), 64'(0));
        check("devid_init", 64'(init_done), 64'(1));
        check("txn_drained_3", 64'(exp_txn.size()), 64'(0));
`endif

        check("xyz_hold", 64'(hold_bad), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
